// File: rtl/dp_mem_arbiter_if.sv
// Bus bundle between the datapath, the arbiter and the single-port RAM.
// The arbiter takes the slave view: it receives datapath requests and
// RAM responses, and drives hits, loads and RAM strobes.
interface dp_mem_arbiter_if;
  // datapath side
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        halt;
  logic        ihit;
  logic [31:0] imemload;
  logic        dhit;
  logic [31:0] dmemload;
  // RAM side
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ram_ready;

  modport slave (
    input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
    input  ramload, ram_ready,
    output ihit, imemload, dhit, dmemload,
    output ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
    output ramload, ram_ready,
    input  ihit, imemload, dhit, dmemload,
    input  ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/dp_mem_arbiter.sv
// Instruction/data arbiter in front of a single-port RAM. Data requests
// win over instruction fetches; an optional one-entry instruction buffer
// answers repeated fetches of the same address without touching the RAM.
module dp_mem_arbiter #(
  parameter int IBUF_EN = 1
) (
  input  logic            CLK,
  input  logic            RST,
  dp_mem_arbiter_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DACC   = 3'd1;
  localparam logic [2:0] S_IACC   = 3'd2;
  localparam logic [2:0] S_DRESP  = 3'd3;
  localparam logic [2:0] S_IRESP  = 3'd4;
  localparam logic [2:0] S_HALTED = 3'd5;

  logic [2:0]  state_q,    state_d;
  logic [31:0] imemload_q, imemload_d;
  logic [31:0] dmemload_q, dmemload_d;
  logic [31:0] ramaddr_q,  ramaddr_d;
  logic [31:0] ramstore_q, ramstore_d;
  logic        dren_q,     dren_d;
  logic        dwen_q,     dwen_d;
  logic [31:0] buf_addr_q, buf_addr_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic        buf_vld_q,  buf_vld_d;
  logic        buf_hit;

  // A fetch hits only when the buffer exists, holds data and matches the address.
  assign buf_hit = (IBUF_EN != 0) && buf_vld_q && (buf_addr_q == bus.imemaddr);

  // Next-state and datapath latching; RAM-side values change only on entry to an access.
  always_comb begin
    state_d    = state_q;
    imemload_d = imemload_q;
    dmemload_d = dmemload_q;
    ramaddr_d  = ramaddr_q;
    ramstore_d = ramstore_q;
    dren_d     = dren_q;
    dwen_d     = dwen_q;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    buf_vld_d  = buf_vld_q;
    case (state_q)
      S_IDLE: begin
        if (bus.halt) begin
          state_d = S_HALTED;
        end else if (bus.dmemREN || bus.dmemWEN) begin
          ramaddr_d  = bus.dmemaddr;
          ramstore_d = bus.dmemstore;
          dwen_d     = bus.dmemWEN;
          dren_d     = bus.dmemREN && !bus.dmemWEN;
          state_d    = S_DACC;
        end else if (bus.imemREN) begin
          if (buf_hit) begin
            imemload_d = buf_data_q;
            state_d    = S_IRESP;
          end else begin
            ramaddr_d = bus.imemaddr;
            state_d   = S_IACC;
          end
        end
      end
      S_DACC: begin
        if (bus.ram_ready) begin
          if (dren_q) dmemload_d = bus.ramload;
          // A write to the buffered address makes the buffered copy stale.
          if (dwen_q && buf_vld_q && (buf_addr_q == ramaddr_q)) buf_vld_d = 1'b0;
          state_d = S_DRESP;
        end
      end
      S_IACC: begin
        if (bus.ram_ready) begin
          imemload_d = bus.ramload;
          if (IBUF_EN != 0) begin
            buf_addr_d = ramaddr_q;
            buf_data_d = bus.ramload;
            buf_vld_d  = 1'b1;
          end
          state_d = S_IRESP;
        end
      end
      S_DRESP:  state_d = S_IDLE;
      S_IRESP:  state_d = S_IDLE;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      imemload_q <= '0;
      dmemload_q <= '0;
      ramaddr_q  <= '0;
      ramstore_q <= '0;
      dren_q     <= 1'b0;
      dwen_q     <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
      buf_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      imemload_q <= imemload_d;
      dmemload_q <= dmemload_d;
      ramaddr_q  <= ramaddr_d;
      ramstore_q <= ramstore_d;
      dren_q     <= dren_d;
      dwen_q     <= dwen_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
      buf_vld_q  <= buf_vld_d;
    end
  end

  assign bus.ihit     = (state_q == S_IRESP);
  assign bus.dhit     = (state_q == S_DRESP);
  assign bus.imemload = imemload_q;
  assign bus.dmemload = dmemload_q;
  assign bus.ramaddr  = ramaddr_q;
  assign bus.ramstore = ramstore_q;
  assign bus.ramREN   = (state_q == S_IACC) || ((state_q == S_DACC) && dren_q);
  assign bus.ramWEN   = (state_q == S_DACC) && dwen_q;

endmodule

// File: tb/tb_dp_mem_arbiter.sv
// Directed bench for dp_mem_arbiter: a per-cycle vector table for the main
// transaction flow, plus short sequences for request drop and no-buffer build.
module tb_dp_mem_arbiter;

  logic CLK;
  logic RST;

  dp_mem_arbiter_if bus ();
  dp_mem_arbiter_if nb ();

  dp_mem_arbiter #(.IBUF_EN(1)) u_dut (.CLK(CLK), .RST(RST), .bus(bus));
  dp_mem_arbiter #(.IBUF_EN(0)) u_nobuf (.CLK(CLK), .RST(RST), .bus(nb));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        iren;
    logic [31:0] iaddr;
    logic        dren;
    logic        dwen;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        halt;
    logic        rdy;
    logic [31:0] rload;
    logic        e_ihit;
    logic        e_dhit;
    logic        e_ren;
    logic        e_wen;
    logic        c_addr;
    logic [31:0] e_raddr;
    logic [31:0] e_rstore;
    logic        c_il;
    logic [31:0] e_il;
    logic        c_dl;
    logic [31:0] e_dl;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(
    input logic rst, input logic iren, input logic [31:0] iaddr,
    input logic dren, input logic dwen, input logic [31:0] daddr, input logic [31:0] dstore,
    input logic halt, input logic rdy, input logic [31:0] rload,
    input logic e_ihit, input logic e_dhit, input logic e_ren, input logic e_wen,
    input logic c_addr, input logic [31:0] e_raddr, input logic [31:0] e_rstore,
    input logic c_il, input logic [31:0] e_il, input logic c_dl, input logic [31:0] e_dl);
    vec_t r;
    r.rst = rst; r.iren = iren; r.iaddr = iaddr;
    r.dren = dren; r.dwen = dwen; r.daddr = daddr; r.dstore = dstore;
    r.halt = halt; r.rdy = rdy; r.rload = rload;
    r.e_ihit = e_ihit; r.e_dhit = e_dhit; r.e_ren = e_ren; r.e_wen = e_wen;
    r.c_addr = c_addr; r.e_raddr = e_raddr; r.e_rstore = e_rstore;
    r.c_il = c_il; r.e_il = e_il; r.c_dl = c_dl; r.e_dl = e_dl;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    RST           = v.rst;
    bus.imemREN   = v.iren;
    bus.imemaddr  = v.iaddr;
    bus.dmemREN   = v.dren;
    bus.dmemWEN   = v.dwen;
    bus.dmemaddr  = v.daddr;
    bus.dmemstore = v.dstore;
    bus.halt      = v.halt;
    bus.ram_ready = v.rdy;
    bus.ramload   = v.rload;
  endtask

  task automatic nb_idle();
    nb.imemREN = 0; nb.imemaddr = 0; nb.dmemREN = 0; nb.dmemWEN = 0;
    nb.dmemaddr = 0; nb.dmemstore = 0; nb.halt = 0; nb.ram_ready = 0; nb.ramload = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // row order: rst iren iaddr | dren dwen daddr dstore | halt rdy rload |
    //            ihit dhit ren wen | c_addr raddr rstore | c_il il | c_dl dl
    vecs.push_back(mk(0,1,32'h40, 0,0,0,0, 0,0,0, 0,0,0,0, 1,32'h0,32'h0, 1,32'h0, 1,32'h0));
    vecs.push_back(mk(0,1,32'h40, 0,0,0,0, 0,0,0, 0,0,1,0, 1,32'h40,32'h0, 0,0, 0,0));
    vecs.push_back(mk(0,1,32'h40, 0,0,0,0, 0,0,0, 0,0,1,0, 1,32'h40,32'h0, 0,0, 0,0));
    vecs.push_back(mk(0,1,32'h40, 0,0,0,0, 0,1,32'h3C010001, 0,0,1,0, 1,32'h40,32'h0, 0,0, 0,0));
    vecs.push_back(mk(0,1,32'h40, 0,0,0,0, 0,0,0, 1,0,0,0, 1,32'h40,32'h0, 1,32'h3C010001, 0,0));
    vecs.push_back(mk(0,1,32'h40, 0,0,0,0, 0,1,32'hBAD0BAD0, 0,0,0,0, 0,0,0, 0,0, 0,0));
    vecs.push_back(mk(0,1,32'h40, 0,0,0,0, 0,1,32'hBAD0BAD0, 1,0,0,0, 0,0,0, 1,32'h3C010001, 0,0));
    vecs.push_back(mk(0,1,32'h40, 0,1,32'h40,32'hDEADBEEF, 0,0,0, 0,0,0,0, 0,0,0, 0,0, 0,0));
    vecs.push_back(mk(0,1,32'h40, 0,1,32'h40,32'hDEADBEEF, 0,1,0, 0,0,0,1, 1,32'h40,32'hDEADBEEF, 0,0, 0,0));
    vecs.push_back(mk(0,1,32'h40, 0,0,0,0, 0,0,0, 0,1,0,0, 0,0,0, 0,0, 0,0));
    vecs.push_back(mk(0,1,32'h40, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0, 0,0, 0,0));
    vecs.push_back(mk(0,1,32'h40, 0,0,0,0, 0,1,32'h11112222, 0,0,1,0, 1,32'h40,32'hDEADBEEF, 0,0, 0,0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 0,0,0, 1,0,0,0, 0,0,0, 1,32'h11112222, 0,0));
    vecs.push_back(mk(0,0,0, 1,0,32'h100,0, 0,0,0, 0,0,0,0, 0,0,0, 0,0, 0,0));
    vecs.push_back(mk(0,0,0, 1,0,32'h100,0, 0,1,32'h12345678, 0,0,1,0, 1,32'h100,32'h0, 0,0, 0,0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 0,0,0, 0,1,0,0, 0,0,0, 0,0, 1,32'h12345678));
    vecs.push_back(mk(0,1,32'h80, 0,0,0,0, 0,0,0, 0,0,0,0, 1,32'h100,32'h0, 0,0, 1,32'h12345678));
    vecs.push_back(mk(0,1,32'h80, 0,0,0,0, 1,0,0, 0,0,1,0, 1,32'h80,32'h0, 0,0, 0,0));
    vecs.push_back(mk(0,1,32'h80, 0,0,0,0, 1,1,32'hCAFEF00D, 0,0,1,0, 0,0,0, 0,0, 0,0));
    vecs.push_back(mk(0,1,32'h80, 0,0,0,0, 1,0,0, 1,0,0,0, 0,0,0, 1,32'hCAFEF00D, 0,0));
    vecs.push_back(mk(0,1,32'h40, 0,0,0,0, 1,0,0, 0,0,0,0, 0,0,0, 0,0, 0,0));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(0,1,32'h40, 1,0,32'h500,0, 0,1,32'h9, 0,0,0,0, 0,0,0, 0,0, 0,0));
    vecs.push_back(mk(1,0,0, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0, 0,0, 0,0));
    vecs.push_back(mk(0,0,0, 0,1,32'h200,32'h5, 0,0,0, 0,0,0,0, 0,0,0, 0,0, 0,0));
    vecs.push_back(mk(1,0,0, 0,1,32'h200,32'h5, 0,1,0, 0,0,0,1, 1,32'h200,32'h5, 0,0, 0,0));
    vecs.push_back(mk(0,1,32'h80, 0,0,0,0, 0,0,0, 0,0,0,0, 1,32'h0,32'h0, 1,32'h0, 1,32'h0));
    vecs.push_back(mk(0,1,32'h80, 0,0,0,0, 0,1,32'h77, 0,0,1,0, 1,32'h80,32'h0, 0,0, 0,0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 0,0,0, 1,0,0,0, 0,0,0, 1,32'h77, 0,0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0, 0,0, 0,0));

    // Power-on reset for both instances.
    RST = 1'b1;
    drive(mk(1,0,0, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0, 0,0, 0,0));
    nb_idle();
    repeat (2) @(posedge CLK);

    // Table: outputs are checked in the same cycle the row's inputs are applied.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      drive(vecs[i]);
      chk($sformatf("row%0d ihit", i),   {31'b0, bus.ihit},   {31'b0, vecs[i].e_ihit});
      chk($sformatf("row%0d dhit", i),   {31'b0, bus.dhit},   {31'b0, vecs[i].e_dhit});
      chk($sformatf("row%0d ramREN", i), {31'b0, bus.ramREN}, {31'b0, vecs[i].e_ren});
      chk($sformatf("row%0d ramWEN", i), {31'b0, bus.ramWEN}, {31'b0, vecs[i].e_wen});
      if (vecs[i].c_addr) begin
        chk($sformatf("row%0d ramaddr", i),  bus.ramaddr,  vecs[i].e_raddr);
        chk($sformatf("row%0d ramstore", i), bus.ramstore, vecs[i].e_rstore);
      end
      if (vecs[i].c_il) chk($sformatf("row%0d imemload", i), bus.imemload, vecs[i].e_il);
      if (vecs[i].c_dl) chk($sformatf("row%0d dmemload", i), bus.dmemload, vecs[i].e_dl);
    end

    // Data read whose request drops during the access still completes.
    begin
      int wait_cyc;
      bit seen;
      @(negedge CLK);
      bus.dmemREN = 1; bus.dmemaddr = 32'h300; bus.ram_ready = 0; bus.ramload = 0;
      @(negedge CLK);
      bus.dmemREN = 0; bus.dmemaddr = 32'h0;
      chk("drop ramREN", {31'b0, bus.ramREN}, 32'd1);
      for (int k = 0; k < 3; k++) begin
        @(negedge CLK);
        chk($sformatf("drop ramaddr hold%0d", k), bus.ramaddr, 32'h300);
      end
      bus.ram_ready = 1; bus.ramload = 32'hA5A5A5A5;
      seen = 0; wait_cyc = 0;
      for (int k = 0; k < 5 && !seen; k++) begin
        @(negedge CLK);
        bus.ram_ready = 0;
        wait_cyc++;
        if (bus.dhit) seen = 1;
      end
      chk("drop dhit seen", {31'b0, seen}, 32'd1);
      chk("drop dhit latency", wait_cyc, 32'd1);
      chk("drop dmemload", bus.dmemload, 32'hA5A5A5A5);
    end

    // Without the buffer, a repeated fetch of the same address goes to RAM again.
    @(negedge CLK);
    nb.imemREN = 1; nb.imemaddr = 32'h40;
    @(negedge CLK);
    chk("nobuf first ramREN", {31'b0, nb.ramREN}, 32'd1);
    nb.ram_ready = 1; nb.ramload = 32'h5555AAAA;
    @(negedge CLK);
    nb.ram_ready = 0;
    chk("nobuf first ihit", {31'b0, nb.ihit}, 32'd1);
    chk("nobuf first imemload", nb.imemload, 32'h5555AAAA);
    @(negedge CLK);
    chk("nobuf idle ramREN", {31'b0, nb.ramREN}, 32'd0);
    @(negedge CLK);
    chk("nobuf refetch ramREN", {31'b0, nb.ramREN}, 32'd1);
    chk("nobuf refetch ihit", {31'b0, nb.ihit}, 32'd0);
    nb.ram_ready = 1; nb.ramload = 32'h0BADF00D;
    @(negedge CLK);
    nb_idle();
    chk("nobuf refetch imemload", nb.imemload, 32'h0BADF00D);

    @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
